coeff_bank_ctrl: RTL and testbench

Ping-pong controller for the 2D FIR coefficient BRAM. It owns both ports of the coefficient dual-port BRAM. Port A takes host writes into the inactive (shadow) bank. Port B streams the 25 active coefficients to the filter at every frame start (vs_i rising edge). A host commit swaps banks atomically on the next vertical sync, so a frame never sees a half-updated kernel.

---
 rtl/coeff_bank_ctrl.sv | 126 ++++++++++++
 tb/tb_coeff_bank_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coeff_bank_ctrl.sv
// coeff_bank_ctrl: ping-pong coefficient bank controller for the 2D FIR.
// Ports: clk/rst; vs_i; host write/commit; BRAM port A (write) and port B
// (read); coefficient stream (vld/idx/val/upd); bank and error status.

module coeff_bank_ctrl #(
  parameter int NCOEFF      = 25,
  parameter int BANK_STRIDE = 32,
  parameter int ADDR_W      = 6,
  parameter int WIDTH       = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     vs_i,
  input  logic                     host_we,
  input  logic [4:0]               host_addr,
  input  logic [WIDTH-1:0]         host_data,
  input  logic                     host_commit,
  output logic                     bram_we_a,
  output logic [ADDR_W-1:0]        bram_addr_a,
  output logic [WIDTH-1:0]         bram_din_a,
  output logic [ADDR_W-1:0]        bram_addr_b,
  input  logic [WIDTH-1:0]         bram_dout_b,
  output logic                     coeff_vld,
  output logic [4:0]               coeff_idx,
  output logic signed [15:0]       coeff_val,
  output logic                     coeff_upd,
  output logic                     active_bank,
  output logic                     commit_pending,
  output logic                     wr_err,
  output logic                     vs_overrun
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(NCOEFF - 1);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(BANK_STRIDE);

  function automatic logic [ADDR_W-1:0] bank_addr(
    input logic       bank,
    input logic [4:0] i
  );
    return (bank ? STRIDE : '0) + ADDR_W'(i);
  endfunction

  state_t     state;
  logic [4:0] idx;
  logic       vs_q;
  logic       vs_rise;
  logic       wr_ok;
  logic       unused_dout_hi;

  assign vs_rise = vs_i & ~vs_q;

  // Shadow bank is frozen from commit until the swap.
  assign wr_ok = host_we
              && (host_addr <= LAST_IDX)
              && !commit_pending;

  assign bram_addr_b = (state == S_LOAD)
                     ? bank_addr(active_bank, idx)
                     : '0;

  assign coeff_val = coeff_vld ? bram_dout_b[15:0] : '0;

  assign unused_dout_hi = ^bram_dout_b[WIDTH-1:16];

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      idx            <= '0;
      vs_q           <= 1'b0;
      bram_we_a      <= 1'b0;
      bram_addr_a    <= '0;
      bram_din_a     <= '0;
      coeff_vld      <= 1'b0;
      coeff_idx      <= '0;
      coeff_upd      <= 1'b0;
      active_bank    <= 1'b0;
      commit_pending <= 1'b0;
      wr_err         <= 1'b0;
      vs_overrun     <= 1'b0;
    end else begin
      vs_q       <= vs_i;
      bram_we_a  <= wr_ok;
      wr_err     <= host_we && !wr_ok;
      vs_overrun <= vs_rise && (state != S_IDLE);
      coeff_vld  <= (state == S_LOAD);
      coeff_idx  <= (state == S_LOAD) ? idx : '0;
      coeff_upd  <= (state == S_FLUSH);

      if (wr_ok) begin
        bram_addr_a <= bank_addr(~active_bank, host_addr);
        bram_din_a  <= host_data;
      end

      // A swap in IDLE below overrides this set.
      if (host_commit) commit_pending <= 1'b1;

      unique case (state)
        S_IDLE: begin
          if (vs_rise) begin
            state <= S_LOAD;
            idx   <= '0;
            if (commit_pending) begin
              active_bank    <= ~active_bank;
              commit_pending <= 1'b0;
            end
          end
        end
        S_LOAD: begin
          if (idx == LAST_IDX) state <= S_FLUSH;
          else idx <= idx + 5'd1;
        end
        S_FLUSH: state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coeff_bank_ctrl.sv
// tb_coeff_bank_ctrl: scoreboard bench for coeff_bank_ctrl with a
// behavioural dual-port BRAM (port A write, port B 1-cycle read).

module tb_coeff_bank_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        vs_i;
  logic        host_we;
  logic [4:0]  host_addr;
  logic [31:0] host_data;
  logic        host_commit;
  logic        bram_we_a;
  logic [5:0]  bram_addr_a;
  logic [31:0] bram_din_a;
  logic [5:0]  bram_addr_b;
  logic [31:0] bram_dout_b;
  logic        coeff_vld;
  logic [4:0]  coeff_idx;
  logic signed [15:0] coeff_val;
  logic        coeff_upd;
  logic        active_bank;
  logic        commit_pending;
  logic        wr_err;
  logic        vs_overrun;

  coeff_bank_ctrl dut (
    .clk(clk), .rst(rst), .vs_i(vs_i),
    .host_we(host_we), .host_addr(host_addr),
    .host_data(host_data), .host_commit(host_commit),
    .bram_we_a(bram_we_a), .bram_addr_a(bram_addr_a),
    .bram_din_a(bram_din_a), .bram_addr_b(bram_addr_b),
    .bram_dout_b(bram_dout_b),
    .coeff_vld(coeff_vld), .coeff_idx(coeff_idx),
    .coeff_val(coeff_val), .coeff_upd(coeff_upd),
    .active_bank(active_bank),
    .commit_pending(commit_pending),
    .wr_err(wr_err), .vs_overrun(vs_overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  idx;
    logic [15:0] val;
  } exp_t;

  exp_t        sb[$];
  exp_t        got;
  logic [31:0] mem [0:63];
  logic [31:0] exp_mem [0:63];
  logic        mem_init;
  logic        exp_bank;
  logic        exp_pending;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int upd_cnt = 0;
  int upd_cyc = 0;
  int ovr_cnt = 0;

  function automatic logic [31:0] init_word(input int a);
    return 32'h5A5A_0000 | 32'(1000 + 3 * a);
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_init) begin
      for (int a = 0; a < 64; a++) mem[a] <= init_word(a);
    end else if (bram_we_a) begin
      mem[bram_addr_a] <= bram_din_a;
    end
    bram_dout_b <= mem[bram_addr_b];
  end

  always @(posedge clk) begin
    #1;
    if (coeff_vld) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL stream_extra: got idx=%0d val=%0d, want none",
                 coeff_idx, coeff_val);
      end else begin
        got = sb.pop_front();
        if ({coeff_idx, coeff_val} !== {got.idx, got.val}) begin
          bad++;
          $display("FAIL stream: got idx=%0d val=%h, want idx=%0d val=%h",
                   coeff_idx, coeff_val, got.idx, got.val);
        end
      end
    end
    if (coeff_upd) begin
      upd_cnt++;
      upd_cyc = cyc;
      total++;
      if (sb.size() != 0) begin
        bad++;
        $display("FAIL upd_early: %0d words left, want 0", sb.size());
      end
    end
    if (vs_overrun) ovr_cnt++;
  end

  task automatic push_load();
    for (int i = 0; i < 25; i++) begin
      got.idx = 5'(i);
      got.val = exp_mem[(exp_bank ? 32 : 0) + i][15:0];
      sb.push_back(got);
    end
  endtask

  task automatic vs_start(output int ct);
    @(negedge clk);
    vs_i = 1'b1;
    @(posedge clk);
    #1 ct = cyc;
    @(negedge clk);
    vs_i = 1'b0;
  endtask

  task automatic wait_upd(input int n0, input int ct, input string nm);
    for (int k = 0; k < 40 && upd_cnt == n0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    total++;
    if (upd_cnt != n0 + 1 || upd_cyc != ct + 26) begin
      bad++;
      $display("FAIL %s_upd: got %0d pulses at +%0d, want 1 at +26",
               nm, upd_cnt - n0, upd_cyc - ct);
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_words: %0d missing, want 0", nm, sb.size());
    end
  endtask

  task automatic do_load(input string nm);
    int ct;
    int n0;
    n0 = upd_cnt;
    if (exp_pending) begin
      exp_bank    = ~exp_bank;
      exp_pending = 1'b0;
    end
    push_load();
    vs_start(ct);
    total++;
    if ({active_bank, commit_pending} !== {exp_bank, exp_pending}) begin
      bad++;
      $display("FAIL %s_bank: got bank=%b pend=%b, want bank=%b pend=%b",
               nm, active_bank, commit_pending, exp_bank, exp_pending);
    end
    wait_upd(n0, ct, nm);
  endtask

  task automatic do_write(
    input logic [4:0]  a,
    input logic [31:0] d,
    input logic        cm,
    input logic        ok,
    input string       nm
  );
    logic [5:0] ea;
    ea = (exp_bank ? 6'd0 : 6'd32) + 6'(a);
    @(negedge clk);
    host_we = 1'b1;
    host_addr = a;
    host_data = d;
    host_commit = cm;
    @(negedge clk);
    host_we = 1'b0;
    host_commit = 1'b0;
    total++;
    if ({bram_we_a, wr_err} !== {ok, ~ok}
        || (ok && {bram_addr_a, bram_din_a} !== {ea, d})) begin
      bad++;
      $display("FAIL %s: got we=%b err=%b a=%0d d=%h, want we=%b a=%0d d=%h",
               nm, bram_we_a, wr_err, bram_addr_a, bram_din_a, ok, ea, d);
    end
    if (ok) exp_mem[ea] = d;
  endtask

  task automatic test_reset();
    mem_init = 1'b1;
    rst = 1'b1;
    vs_i = 1'b0;
    host_we = 1'b0;
    host_addr = '0;
    host_data = '0;
    host_commit = 1'b0;
    for (int a = 0; a < 64; a++) exp_mem[a] = init_word(a);
    exp_bank = 1'b0;
    exp_pending = 1'b0;
    repeat (3) @(negedge clk);
    mem_init = 1'b0;
    rst = 1'b0;
    total++;
    if ({bram_we_a, bram_addr_a, bram_din_a, bram_addr_b, coeff_vld,
         coeff_idx, coeff_val, coeff_upd, active_bank, commit_pending,
         wr_err, vs_overrun} !== '0) begin
      bad++;
      $display("FAIL reset: outputs nonzero, bank=%b pend=%b vld=%b",
               active_bank, commit_pending, coeff_vld);
    end
  endtask

  task automatic test_write_commit_load();
    for (int i = 0; i <= 25; i++) begin
      @(negedge clk);
      if (i > 0) begin
        total++;
        if ({bram_we_a, wr_err, bram_addr_a, bram_din_a}
            !== {2'b10, 6'(32 + i - 1), 32'(100 + i - 1)}) begin
          bad++;
          $display("FAIL b2b_write%0d: got we=%b a=%0d d=%0d, want a=%0d d=%0d",
                   i - 1, bram_we_a, bram_addr_a, bram_din_a,
                   32 + i - 1, 100 + i - 1);
        end
      end
      if (i < 25) begin
        host_we = 1'b1;
        host_addr = 5'(i);
        host_data = 32'(100 + i);
        exp_mem[32 + i] = 32'(100 + i);
      end else begin
        host_we = 1'b0;
      end
    end
    host_commit = 1'b1;
    @(negedge clk);
    host_commit = 1'b0;
    exp_pending = 1'b1;
    total++;
    if (commit_pending !== 1'b1) begin
      bad++;
      $display("FAIL commit: got pend=%b, want 1", commit_pending);
    end
    do_load("first_load");
  endtask

  task automatic test_reload();
    do_load("reload");
  endtask

  task automatic test_commit_mid_load();
    int ct;
    int n0;
    n0 = upd_cnt;
    push_load();
    vs_start(ct);
    repeat (4) @(negedge clk);
    host_commit = 1'b1;
    @(negedge clk);
    host_commit = 1'b0;
    wait_upd(n0, ct, "mid_commit");
    exp_pending = 1'b1;
    total++;
    if ({active_bank, commit_pending} !== {exp_bank, 1'b1}) begin
      bad++;
      $display("FAIL mid_commit_hold: got bank=%b pend=%b, want %b 1",
               active_bank, commit_pending, exp_bank);
    end
    do_load("mid_commit_swap");
  endtask

  task automatic test_overrun();
    int ct;
    int n0;
    int o0;
    n0 = upd_cnt;
    o0 = ovr_cnt;
    push_load();
    vs_start(ct);
    repeat (9) @(negedge clk);
    vs_i = 1'b1;
    @(negedge clk);
    vs_i = 1'b0;
    wait_upd(n0, ct, "overrun");
    total++;
    if (ovr_cnt != o0 + 1 || active_bank !== exp_bank) begin
      bad++;
      $display("FAIL overrun: got %0d pulses bank=%b, want 1 bank=%b",
               ovr_cnt - o0, active_bank, exp_bank);
    end
  endtask

  task automatic test_write_errors();
    do_write(5'd25, 32'h1234_0025, 1'b0, 1'b0, "addr_range");
    do_write(5'd3, 32'h0000_ABCD, 1'b1, 1'b1, "commit_same_cycle");
    exp_pending = 1'b1;
    total++;
    if (commit_pending !== 1'b1) begin
      bad++;
      $display("FAIL commit_same_pend: got %b, want 1", commit_pending);
    end
    do_write(5'd4, 32'h0000_7777, 1'b0, 1'b0, "write_after_commit");
    do_load("errors_swap");
  endtask

  task automatic test_reset_mid_load();
    int ct;
    int n0;
    bit hit;
    n0 = upd_cnt;
    hit = 1'b0;
    push_load();
    vs_start(ct);
    for (int k = 0; k < 30 && !hit; k++) begin
      @(negedge clk);
      if (coeff_vld && coeff_idx == 5'd12) hit = 1'b1;
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL rst_wait: idx 12 not seen, want seen");
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    total++;
    if ({bram_we_a, bram_addr_b, coeff_vld, coeff_idx, coeff_val,
         coeff_upd, active_bank, commit_pending, wr_err,
         vs_overrun} !== '0) begin
      bad++;
      $display("FAIL rst_mid_outputs: got vld=%b bank=%b upd=%b, want 0",
               coeff_vld, active_bank, coeff_upd);
    end
    repeat (30) @(negedge clk);
    total++;
    if (upd_cnt != n0) begin
      bad++;
      $display("FAIL rst_mid_upd: got %0d pulses, want 0", upd_cnt - n0);
    end
    exp_bank = 1'b0;
    exp_pending = 1'b0;
    do_load("post_rst");
  endtask

  initial begin
    test_reset();
    test_write_commit_load();
    test_reload();
    test_commit_mid_load();
    test_overrun();
    test_write_errors();
    test_reset_mid_load();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
